// File: rtl/sys_array_input_skew.sv
// Input skew feeder for the weight-stationary systolic array.
// Accepts one vector per handshake and re-times it into a diagonal wavefront:
// lane k is delayed k cycles behind lane 0. Idle slots and unused lanes are
// zero. After the last vector it drains the wavefront and pulses done.
module sys_array_input_skew #(
    parameter int DATA_WIDTH  = 8,
    parameter int ARRAY_MAX_L = 10,
    parameter int LW          = $clog2(ARRAY_MAX_L)
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [LW-1:0]                             cfg_lanes_m1,
    input  logic                                      start,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic                                      in_last,
    input  logic [0:ARRAY_MAX_L-1][DATA_WIDTH-1:0]    in_data,
    output logic [0:ARRAY_MAX_L-1][DATA_WIDTH-1:0]    out_data,
    output logic                                      busy,
    output logic                                      done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [LW-1:0] MAX_M1 = LW'(ARRAY_MAX_L - 1);

    state_t          state;
    state_t          state_next;
    logic [LW-1:0]   lanes_m1;
    logic [LW-1:0]   flush_cnt;
    logic            accept;

    assign accept   = in_valid && (state == S_STREAM);
    assign in_ready = (state == S_STREAM);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

    // State register, clamped lane-count latch and flush countdown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            lanes_m1  <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && start) begin
                lanes_m1 <= (cfg_lanes_m1 > MAX_M1) ? MAX_M1 : cfg_lanes_m1;
            end
            if (state == S_STREAM) begin
                flush_cnt <= lanes_m1 - LW'(1);
            end else if (state == S_FLUSH) begin
                flush_cnt <= flush_cnt - LW'(1);
            end
        end
    end

    // Next-state logic: FLUSH covers the L-1 cycles needed to drain the
    // highest lane, and a single-lane batch has nothing to drain.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_STREAM;
            S_STREAM: if (accept && in_last)
                          state_next = (lanes_m1 == '0) ? S_DONE : S_FLUSH;
            S_FLUSH:  if (flush_cnt == '0) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Per-lane delay lines. Lane k holds k+1 registers: the input register
    // plus k cycles of skew. Inactive lanes are zeroed on entry and at output.
    for (genvar k = 0; k < ARRAY_MAX_L; k++) begin : g_lane
        logic [DATA_WIDTH-1:0] line [0:k];
        logic                  lane_en;

        assign lane_en = (LW'(k) <= lanes_m1);

        // Shift one column per cycle; non-accept cycles inject zero.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int j = 0; j <= k; j++) begin
                    line[j] <= '0;
                end
            end else begin
                line[0] <= (accept && lane_en) ? in_data[k] : '0;
                for (int j = 1; j <= k; j++) begin
                    line[j] <= line[j-1];
                end
            end
        end

        assign out_data[k] = lane_en ? line[k] : '0;
    end

endmodule

// File: tb/tb_sys_array_input_skew.sv
// Directed testbench for sys_array_input_skew: reset, back-to-back stream,
// bubbles, full-width clamp, single lane and control robustness.
module tb_sys_array_input_skew;

    localparam int DW = 8;
    localparam int NL = 10;
    localparam int LW = $clog2(NL);

    typedef logic [0:NL-1][DW-1:0] vec_t;

    logic          clk;
    logic          reset;
    logic [LW-1:0] cfg_lanes_m1;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    vec_t          in_data;
    vec_t          out_data;
    logic          busy;
    logic          done;

    int n_checks;
    int n_fail;

    sys_array_input_skew #(
        .DATA_WIDTH (DW),
        .ARRAY_MAX_L(NL),
        .LW         (LW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_lanes_m1(cfg_lanes_m1),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_last     (in_last),
        .in_data     (in_data),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vec_t exp;
        reset = 1'b1;
        start = 1'b1;
        in_valid = 1'b1;
        in_last = 1'b1;
        cfg_lanes_m1 = 4'd3;
        for (int k = 0; k < NL; k++) in_data[k] = 8'h77;
        step();
        step();
        exp = '0;
        n_checks++;
        if (out_data !== exp) begin
            n_fail++;
            $display("[TB] FAIL reset_out: got %h expected %h", out_data, exp);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        end
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_done: got %b expected 0", done);
        end
        start = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        reset = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL post_reset_idle: got busy=%b in_ready=%b expected 0 0", busy, in_ready);
        end
    endtask

    // Five back-to-back beats on two lanes; first beat is offered with start
    // and must not be taken until the following edge.
    task automatic test_l2_stream();
        vec_t exp;
        cfg_lanes_m1 = 4'd1;
        start = 1'b1;
        in_valid = 1'b1;
        in_last = 1'b0;
        for (int k = 0; k < NL; k++) in_data[k] = 8'hAA;
        in_data[0] = 8'd1;
        in_data[1] = 8'd2;
        step();
        start = 1'b0;
        exp = '0;
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || out_data !== exp) begin
            n_fail++;
            $display("[TB] FAIL l2_start: got busy=%b rdy=%b out=%h expected 1 1 %h", busy, in_ready, out_data, exp);
        end
        for (int b = 0; b < 5; b++) begin
            in_data[0] = 8'(2*b + 1);
            in_data[1] = 8'(2*b + 2);
            in_last = (b == 4);
            step();
            exp = '0;
            exp[0] = 8'(2*b + 1);
            exp[1] = (b == 0) ? 8'd0 : 8'(2*b);
            n_checks++;
            if (out_data !== exp || done !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL l2_beat%0d: got out=%h done=%b expected %h 0", b, out_data, done, exp);
            end
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        step();
        exp = '0;
        exp[1] = 8'd10;
        n_checks++;
        if (out_data !== exp || done !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL l2_done: got out=%h done=%b busy=%b expected %h 1 1", out_data, done, busy, exp);
        end
        step();
        exp = '0;
        n_checks++;
        if (out_data !== exp || done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL l2_idle: got out=%h done=%b busy=%b rdy=%b expected %h 0 0 0", out_data, done, busy, in_ready, exp);
        end
    endtask

    // Bubble after the second beat; in_last during the bubble and a start
    // pulse mid-stream must both be ignored.
    task automatic test_bubble();
        int   v [8]  = '{1, 1, 0, 1, 1, 1, 0, 0};
        int   d0 [8] = '{1, 3, 0, 5, 7, 9, 0, 0};
        int   d1 [8] = '{2, 4, 0, 6, 8, 10, 0, 0};
        int   lst [8] = '{0, 0, 1, 0, 0, 1, 0, 0};
        int   st [8] = '{0, 0, 0, 1, 0, 0, 0, 0};
        int   e0 [8] = '{1, 3, 0, 5, 7, 9, 0, 0};
        int   e1 [8] = '{0, 2, 4, 0, 6, 8, 10, 0};
        int   ed [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
        vec_t exp;
        cfg_lanes_m1 = 4'd1;
        start = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        for (int k = 0; k < NL; k++) in_data[k] = 8'h5C;
        step();
        for (int i = 0; i < 8; i++) begin
            start = st[i][0];
            in_valid = v[i][0];
            in_last = lst[i][0];
            in_data[0] = 8'(d0[i]);
            in_data[1] = 8'(d1[i]);
            step();
            exp = '0;
            exp[0] = 8'(e0[i]);
            exp[1] = 8'(e1[i]);
            n_checks++;
            if (out_data !== exp || done !== ed[i][0] || busy !== (i < 7)) begin
                n_fail++;
                $display("[TB] FAIL bubble_cyc%0d: got out=%h done=%b busy=%b expected %h %0d %0d", i, out_data, done, busy, exp, ed[i], (i < 7));
            end
        end
        start = 1'b0;
    endtask

    // Oversized lane count clamps to all ten lanes; a single beat walks the
    // diagonal. A cfg change mid-batch must not matter.
    task automatic test_full_width();
        vec_t exp;
        cfg_lanes_m1 = 4'd15;
        start = 1'b1;
        in_valid = 1'b0;
        step();
        start = 1'b0;
        cfg_lanes_m1 = 4'd0;
        in_valid = 1'b1;
        in_last = 1'b1;
        for (int k = 0; k < NL; k++) in_data[k] = 8'(k + 1);
        for (int c = 0; c < 11; c++) begin
            step();
            in_valid = 1'b0;
            in_last = 1'b0;
            exp = '0;
            if (c < NL) exp[c] = 8'(c + 1);
            n_checks++;
            if (out_data !== exp || done !== (c == 9) || busy !== (c <= 9)) begin
                n_fail++;
                $display("[TB] FAIL full_cyc%0d: got out=%h done=%b busy=%b expected %h %0d %0d", c, out_data, done, busy, exp, (c == 9), (c <= 9));
            end
        end
    endtask

    task automatic test_single_lane();
        vec_t exp;
        cfg_lanes_m1 = 4'd0;
        start = 1'b1;
        in_valid = 1'b0;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        in_last = 1'b1;
        for (int k = 0; k < NL; k++) in_data[k] = 8'h66;
        in_data[0] = 8'h55;
        step();
        in_valid = 1'b0;
        in_last = 1'b0;
        exp = '0;
        exp[0] = 8'h55;
        n_checks++;
        if (out_data !== exp || done !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL l1_done: got out=%h done=%b busy=%b expected %h 1 1", out_data, done, busy, exp);
        end
        step();
        exp = '0;
        n_checks++;
        if (out_data !== exp || done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL l1_idle: got out=%h done=%b busy=%b expected %h 0 0", out_data, done, busy, exp);
        end
    endtask

    // Reset asserted mid-flush clears outputs at once, done never fires,
    // and a following two-lane batch behaves normally.
    task automatic test_reset_mid_flush();
        vec_t exp;
        cfg_lanes_m1 = 4'd9;
        start = 1'b1;
        in_valid = 1'b0;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        in_last = 1'b1;
        for (int k = 0; k < NL; k++) in_data[k] = 8'(8'h10 + k);
        step();
        in_valid = 1'b0;
        in_last = 1'b0;
        step();
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        exp = '0;
        n_checks++;
        if (out_data !== exp || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL flush_reset: got out=%h busy=%b done=%b expected %h 0 0", out_data, busy, done, exp);
        end
        step();
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            n_checks++;
            if (done !== 1'b0 || out_data !== exp) begin
                n_fail++;
                $display("[TB] FAIL flush_quiet%0d: got done=%b out=%h expected 0 %h", c, done, out_data, exp);
            end
        end
        cfg_lanes_m1 = 4'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        in_last = 1'b1;
        in_data = '0;
        in_data[0] = 8'h11;
        in_data[1] = 8'h22;
        step();
        in_valid = 1'b0;
        in_last = 1'b0;
        exp = '0;
        exp[0] = 8'h11;
        n_checks++;
        if (out_data !== exp || done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rebatch_lane0: got out=%h done=%b expected %h 0", out_data, done, exp);
        end
        step();
        exp = '0;
        exp[1] = 8'h22;
        n_checks++;
        if (out_data !== exp || done !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rebatch_done: got out=%h done=%b expected %h 1", out_data, done, exp);
        end
        step();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rebatch_idle: got busy=%b expected 0", busy);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        reset = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data = '0;
        cfg_lanes_m1 = '0;
        test_reset();
        test_l2_stream();
        test_bubble();
        test_full_width();
        test_single_lane();
        test_reset_mid_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
